// File: rtl/register_file_sb_if.sv
// Register file bundle between ID/WB stages and the register file:
// read ports, writeback, issue marking, hazards and debug read.
interface register_file_sb_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4
);
  logic [ADDR_W-1:0] src1;
  logic [ADDR_W-1:0] src2;
  logic [DATA_W-1:0] reg1;
  logic [DATA_W-1:0] reg2;
  logic              hazard1;
  logic              hazard2;
  logic              writeBackEn;
  logic [ADDR_W-1:0] Dest_wb;
  logic [DATA_W-1:0] Result_WB;
  logic              issue_en;
  logic [ADDR_W-1:0] issue_dest;
  logic [ADDR_W:0]   pending_count;
  logic [ADDR_W-1:0] dbg_sel;
  logic [DATA_W-1:0] dbg_data;

  modport master (
    output src1, src2, writeBackEn, Dest_wb, Result_WB,
    output issue_en, issue_dest, dbg_sel,
    input  reg1, reg2, hazard1, hazard2,
    input  pending_count, dbg_data
  );

  modport slave (
    input  src1, src2, writeBackEn, Dest_wb, Result_WB,
    input  issue_en, issue_dest, dbg_sel,
    output reg1, reg2, hazard1, hazard2,
    output pending_count, dbg_data
  );
endinterface

// File: rtl/register_file_sb.sv
// Parametrised register file with writeback bypass, RAW pending
// scoreboard, pending counter and an unbypassed debug read port.
module register_file_sb #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 4,
  parameter int NUM_REGS    = 16,
  parameter bit RESET_INDEX = 1'b1,
  parameter bit BYPASS      = 1'b1
) (
  input logic               clk,
  input logic               rst,
  register_file_sb_if.slave rf
);

  localparam logic [ADDR_W:0] NR = NUM_REGS[ADDR_W:0];

  logic [DATA_W-1:0]   regs [NUM_REGS];
  logic [NUM_REGS-1:0] pend;
  logic [NUM_REGS-1:0] pend_n;
  logic [ADDR_W:0]     cnt;
  logic [ADDR_W:0]     cnt_n;

  logic wb_ok;
  logic iss_ok;
  logic s1_ok;
  logic s2_ok;
  logic dbg_ok;
  logic byp1;
  logic byp2;
  logic inc;
  logic dec;

  assign wb_ok  = rf.writeBackEn && ({1'b0, rf.Dest_wb} < NR);
  assign iss_ok = rf.issue_en && ({1'b0, rf.issue_dest} < NR);
  assign s1_ok  = {1'b0, rf.src1} < NR;
  assign s2_ok  = {1'b0, rf.src2} < NR;
  assign dbg_ok = {1'b0, rf.dbg_sel} < NR;

  // Forwarding only matters for in-range sources; the rest read as 0.
  assign byp1 = BYPASS && wb_ok && (rf.Dest_wb == rf.src1);
  assign byp2 = BYPASS && wb_ok && (rf.Dest_wb == rf.src2);

  assign rf.reg1 = byp1 ? rf.Result_WB :
                   s1_ok ? regs[rf.src1] : '0;
  assign rf.reg2 = byp2 ? rf.Result_WB :
                   s2_ok ? regs[rf.src2] : '0;

  assign rf.dbg_data = dbg_ok ? regs[rf.dbg_sel] : '0;

  assign rf.hazard1 = s1_ok && pend[rf.src1] && !byp1;
  assign rf.hazard2 = s2_ok && pend[rf.src2] && !byp2;

  assign rf.pending_count = cnt;

  always_comb begin
    pend_n = pend;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (wb_ok && rf.Dest_wb == ADDR_W'(i))
        pend_n[i] = 1'b0;
      // A new producer overrides a same-cycle writeback.
      if (iss_ok && rf.issue_dest == ADDR_W'(i))
        pend_n[i] = 1'b1;
    end
  end

  always_comb begin
    inc = iss_ok && !pend[rf.issue_dest];
    dec = wb_ok && pend[rf.Dest_wb] &&
          !(iss_ok && rf.issue_dest == rf.Dest_wb);
    cnt_n = cnt;
    if (inc && !dec)
      cnt_n = cnt + 1'b1;
    else if (dec && !inc)
      cnt_n = cnt - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++)
        regs[i] <= RESET_INDEX ? DATA_W'(i) : '0;
      pend <= '0;
      cnt  <= '0;
    end else begin
      if (wb_ok)
        regs[rf.Dest_wb] <= rf.Result_WB;
      pend <= pend_n;
      cnt  <= cnt_n;
    end
  end

endmodule

// File: tb/tb_register_file_sb.sv
// Directed bench for register_file_sb: default, no-bypass and
// 12-register instances with hand-computed expectations.
module tb_register_file_sb;

  logic clk;
  logic rst;

  int n_cmp;
  int n_bad;

  register_file_sb_if #(.DATA_W(32), .ADDR_W(4)) ia ();
  register_file_sb_if #(.DATA_W(32), .ADDR_W(4)) ib ();
  register_file_sb_if #(.DATA_W(32), .ADDR_W(4)) ic ();

  register_file_sb u_dut (
    .clk (clk),
    .rst (rst),
    .rf  (ia.slave)
  );

  register_file_sb #(.BYPASS(1'b0)) u_nb (
    .clk (clk),
    .rst (rst),
    .rf  (ib.slave)
  );

  register_file_sb #(.NUM_REGS(12)) u_n12 (
    .clk (clk),
    .rst (rst),
    .rf  (ic.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst = 1'b0;
    ia.src1 = '0; ia.src2 = '0; ia.writeBackEn = 1'b0;
    ia.Dest_wb = '0; ia.Result_WB = '0; ia.issue_en = 1'b0;
    ia.issue_dest = '0; ia.dbg_sel = '0;
    ib.src1 = '0; ib.src2 = '0; ib.writeBackEn = 1'b0;
    ib.Dest_wb = '0; ib.Result_WB = '0; ib.issue_en = 1'b0;
    ib.issue_dest = '0; ib.dbg_sel = '0;
    ic.src1 = '0; ic.src2 = '0; ic.writeBackEn = 1'b0;
    ic.Dest_wb = '0; ic.Result_WB = '0; ic.issue_en = 1'b0;
    ic.issue_dest = '0; ic.dbg_sel = '0;

    // Reset and default contents
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < 16; i++) begin
      ia.src1 = 4'(i);
      ia.src2 = 4'(15 - i);
      #1;
      chk("rst_reg1", ia.reg1, 64'(i));
      chk("rst_reg2", ia.reg2, 64'(15 - i));
      chk("rst_haz1", ia.hazard1, 0);
      chk("rst_haz2", ia.hazard2, 0);
    end
    chk("rst_cnt", ia.pending_count, 0);

    // Write with and without bypass
    ia.writeBackEn = 1'b1; ia.Dest_wb = 4'd3;
    ia.Result_WB = 32'hDEADBEEF; ia.src1 = 4'd3; ia.dbg_sel = 4'd3;
    ib.writeBackEn = 1'b1; ib.Dest_wb = 4'd3;
    ib.Result_WB = 32'hDEADBEEF; ib.src1 = 4'd3; ib.dbg_sel = 4'd3;
    #1;
    chk("byp_reg1", ia.reg1, 64'hDEADBEEF);
    chk("byp_dbg0", ia.dbg_data, 3);
    chk("nb_reg1_0", ib.reg1, 3);
    step();
    ia.writeBackEn = 1'b0;
    ib.writeBackEn = 1'b0;
    #1;
    chk("byp_dbg1", ia.dbg_data, 64'hDEADBEEF);
    chk("byp_reg1_1", ia.reg1, 64'hDEADBEEF);
    chk("nb_reg1_1", ib.reg1, 64'hDEADBEEF);
    chk("nb_dbg1", ib.dbg_data, 64'hDEADBEEF);

    // Scoreboard lifecycle on 7
    ia.issue_en = 1'b1; ia.issue_dest = 4'd7; ia.src1 = 4'd7;
    #1;
    chk("iss_nohaz", ia.hazard1, 0);
    step();
    ia.issue_en = 1'b0;
    #1;
    chk("sb_haz1", ia.hazard1, 1);
    chk("sb_cnt1", ia.pending_count, 1);
    ia.writeBackEn = 1'b1; ia.Dest_wb = 4'd7; ia.Result_WB = 32'h77;
    #1;
    chk("sb_wb_haz", ia.hazard1, 0);
    chk("sb_wb_reg", ia.reg1, 64'h77);
    chk("sb_wb_cnt", ia.pending_count, 1);
    step();
    ia.writeBackEn = 1'b0;
    #1;
    chk("sb_cnt0", ia.pending_count, 0);
    chk("sb_haz0", ia.hazard1, 0);

    // Same-register issue and writeback while pending
    ia.issue_en = 1'b1; ia.issue_dest = 4'd4;
    step();
    ia.writeBackEn = 1'b1; ia.Dest_wb = 4'd4; ia.Result_WB = 32'h44;
    step();
    ia.issue_en = 1'b0; ia.writeBackEn = 1'b0;
    ia.src1 = 4'd4;
    #1;
    chk("same_cnt", ia.pending_count, 1);
    chk("same_haz", ia.hazard1, 1);
    chk("same_data", ia.reg1, 64'h44);

    // Issue 5 with writeback 4
    ia.issue_en = 1'b1; ia.issue_dest = 4'd5;
    ia.writeBackEn = 1'b1; ia.Dest_wb = 4'd4; ia.Result_WB = 32'h45;
    step();
    ia.issue_en = 1'b0; ia.writeBackEn = 1'b0;
    ia.src1 = 4'd5; ia.src2 = 4'd4;
    #1;
    chk("diff_cnt", ia.pending_count, 1);
    chk("diff_haz5", ia.hazard1, 1);
    chk("diff_haz4", ia.hazard2, 0);

    // Drain 5, then re-issue 2 twice
    ia.writeBackEn = 1'b1; ia.Dest_wb = 4'd5; ia.Result_WB = 32'h55;
    step();
    ia.writeBackEn = 1'b0;
    #1;
    chk("drain_cnt", ia.pending_count, 0);
    ia.issue_en = 1'b1; ia.issue_dest = 4'd2;
    step();
    step();
    ia.issue_en = 1'b0;
    #1;
    chk("reiss_cnt", ia.pending_count, 1);

    // Stray writeback to non-pending 9
    ia.writeBackEn = 1'b1; ia.Dest_wb = 4'd9; ia.Result_WB = 32'h99;
    ia.dbg_sel = 4'd9;
    step();
    ia.writeBackEn = 1'b0;
    #1;
    chk("stray_cnt", ia.pending_count, 1);
    chk("stray_dbg", ia.dbg_data, 64'h99);

    // 12-register instance: reset mid-operation
    ic.writeBackEn = 1'b1; ic.Dest_wb = 4'd1; ic.Result_WB = 32'hAA;
    ic.issue_en = 1'b1; ic.issue_dest = 4'd1;
    step();
    ic.writeBackEn = 1'b0;
    ic.issue_dest = 4'd2;
    step();
    ic.issue_dest = 4'd3;
    step();
    ic.issue_en = 1'b0;
    ic.src1 = 4'd1;
    #1;
    chk("n12_cnt3", ic.pending_count, 3);
    chk("n12_pre", ic.reg1, 64'hAA);
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    chk("n12_rcnt", ic.pending_count, 0);
    chk("n12_rreg", ic.reg1, 1);
    chk("n12_rhaz", ic.hazard1, 0);

    // Out-of-range writeback, issue and reads
    ic.writeBackEn = 1'b1; ic.Dest_wb = 4'd13; ic.Result_WB = 32'hFF;
    ic.issue_en = 1'b1; ic.issue_dest = 4'd13;
    step();
    ic.writeBackEn = 1'b0; ic.issue_en = 1'b0;
    ic.src1 = 4'd13; ic.src2 = 4'd11; ic.dbg_sel = 4'd13;
    #1;
    chk("oor_reg1", ic.reg1, 0);
    chk("oor_haz1", ic.hazard1, 0);
    chk("oor_reg2", ic.reg2, 11);
    chk("oor_dbg", ic.dbg_data, 0);
    chk("oor_cnt", ic.pending_count, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/register_file_sb.md
Name: register_file_sb

Overview:
- Parametrised successor to the pipeline's 16x32 register file.
- Generalised in data width and register count.
- Adds a same-cycle write-to-read bypass, a per-register pending scoreboard for RAW-hazard detection, a pending-count counter and an indexed debug read port.
- Sits between the ID stage (reads, issue marking) and the WB stage (writeback).

Parameters:
- DATA_W, 32, register data width in bits.
- ADDR_W, 4, register index width.
- NUM_REGS, 16, implemented registers; legal range 2..2**ADDR_W.
- RESET_INDEX, 1, 1: register i resets to i (zero-extended/truncated to DATA_W); 0: all registers reset to 0.
- BYPASS, 1, 1: a same-cycle writeback is forwarded to the read ports; 0: reads return the stored value only.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- src1  input  ADDR_W  read port 1 index.
- src2  input  ADDR_W  read port 2 index.
- reg1  output  DATA_W  read port 1 data.
- reg2  output  DATA_W  read port 2 data.
- hazard1  output  1  src1 has an outstanding producer.
- hazard2  output  1  src2 has an outstanding producer.
- writeBackEn  input  1  writeback enable.
- Dest_wb  input  ADDR_W  writeback destination.
- Result_WB  input  DATA_W  writeback data.
- issue_en  input  1  instruction with a destination issued this cycle.
- issue_dest  input  ADDR_W  destination to mark pending.
- pending_count  output  ADDR_W+1  number of registers currently pending.
- dbg_sel  input  ADDR_W  debug read index.
- dbg_data  output  DATA_W  debug read data; never bypassed.

Behaviour:
- Reset:
  - On a rising edge with rst=1, all NUM_REGS registers are loaded. Value is i if RESET_INDEX=1, else 0. This includes the last register, NUM_REGS-1.
  - All pending bits clear; pending_count=0.
  - rst has priority over writeBackEn and issue_en in the same cycle.
  - Reset mid-operation discards all outstanding pending state.
- Read ports (combinational):
  - reg1 = Result_WB if BYPASS=1 and writeBackEn=1 and Dest_wb==src1; otherwise the stored value of src1.
  - reg2 follows the same rule with src2.
  - A src index >= NUM_REGS returns 0.
  - After reset, reg1/reg2 show the reset contents, e.g. src1=5 gives 5 when RESET_INDEX=1.
- Write: on the rising edge, if writeBackEn=1 and Dest_wb < NUM_REGS, the register takes Result_WB. Out-of-range writes are ignored. Stored-value latency is 1 cycle; with BYPASS=1 the value is visible on the read ports in the same cycle.
- Scoreboard, per register, on the rising edge:
  - issue_en=1 only: bit sets.
  - writeBackEn=1 only: bit clears.
  - Both to the same register in the same cycle: bit ends set, because the new producer wins.
  - Out-of-range indices have no effect.
- hazardN (combinational):
  - hazardN = pending[srcN] AND NOT (BYPASS=1 AND writeBackEn=1 AND Dest_wb==srcN).
  - An issue in the current cycle does not raise a hazard until the next cycle.
  - An out-of-range src gives hazard=0.
- pending_count (registered):
  - +1 when a clear bit becomes set.
  - -1 when a set bit becomes clear.
  - Net 0 when both events hit different registers in the same cycle.
  - Unchanged on an issue to an already-pending register, a writeback to a non-pending register, or a same-register issue+writeback on a pending register.
  - Always equals the popcount of the pending bits; never wraps.
- dbg_data: stored value of dbg_sel, combinational; 0 if dbg_sel >= NUM_REGS.

Test Plan:
- Reset, defaults (RESET_INDEX=1): pulse rst for 1 cycle, then sweep src1/src2 over 0..15 -> regN==index including 15; hazard1/2=0; pending_count=0.
- Write and bypass: writeBackEn=1, Dest_wb=3, Result_WB=0xDEADBEEF, src1=3 -> reg1=0xDEADBEEF in the same cycle. With BYPASS=0, reg1=3 in that cycle and 0xDEADBEEF next cycle. dbg_sel=3 -> dbg_data=3 in that cycle and 0xDEADBEEF next cycle.
- Scoreboard lifecycle: issue 7, then src1=7 -> hazard1=1 and pending_count=1. Writeback 7 with BYPASS=1 -> hazard1=0 that cycle; pending_count=0 next cycle.
- Simultaneous events:
  - Issue 4 and writeback 4 in the same cycle, with 4 pending -> 4 stays pending; count unchanged.
  - Issue 5 and writeback 4 in the same cycle -> count unchanged; 5 set, 4 clear.
- Re-issue and stray writeback: issue 2 twice -> count=1. Writeback 9 while 9 is not pending -> data written; count unchanged.
- Reset mid-operation and out-of-range (NUM_REGS=12):
  - Reset with 3 registers pending -> count=0 and contents restored.
  - Writeback to index 13 -> no change.
  - src1=13 -> reg1=0 and hazard1=0.
